// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision definitions for the FPU divide/multiply units.
// Holds field widths, special encodings, FSM state and operand class types.
package fp32_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int QBITS = 27;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIV,
        ST_NORM,
        ST_SPEC,
        ST_DONE
    } div_state_e;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORMAL,
        FP_INF,
        FP_NAN
    } fp_class_e;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        dbz;
        logic        inv;
    } div_out_t;

    function automatic logic [31:0] signed_inf(input logic s);
        return s ? NEG_INF : POS_INF;
    endfunction

endpackage

// File: rtl/fp32_unpack.sv
// Splits an IEEE-754 single into sign/exponent/mantissa (hidden bit restored)
// and classifies it; exponent field 0 is always treated as zero (flush-to-zero).
module fp32_unpack
    import fp32_pkg::*;
(
    input  logic [31:0]      i_op,
    output logic             o_sign,
    output logic [EXP_W-1:0] o_exp,
    output logic [MAN_W:0]   o_man,
    output fp_class_e        o_cls
);

    assign o_sign = i_op[31];
    assign o_exp  = i_op[30:23];
    assign o_man  = {1'b1, i_op[22:0]};

    always_comb begin
        o_cls = FP_NORMAL;
        if (i_op[30:23] == '0) begin
            o_cls = FP_ZERO;
        end else if (i_op[30:23] == '1) begin
            o_cls = (i_op[22:0] == '0) ? FP_INF : FP_NAN;
        end
    end

endmodule

// File: rtl/divider_32bit.sv
// IEEE-754 single-precision divider: iterative restoring mantissa divide,
// round-to-nearest-even, flush-to-zero, one operation in flight.
module divider_32bit
    import fp32_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_vld,
    output logic [31:0] o_res,
    output logic        o_res_vld,
    output logic        o_busy,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero,
    output logic        invalid
);

    localparam int ITERS = QBITS / BITS_PER_CYCLE;
    localparam int CNT_W = 5;
    localparam logic signed [9:0] BIAS_S = 10'(BIAS);

    function automatic logic [24:0] round_rne(input logic [23:0] man, input logic g, input logic s);
        return {1'b0, man} + {24'd0, g & (s | man[0])};
    endfunction

    function automatic div_out_t pack_norm(input logic sign, input logic signed [9:0] e,
                                           input logic [22:0] frac);
        div_out_t r;
        r = '0;
        if (e >= 10'sd255) begin
            r.res = signed_inf(sign);
            r.ovf = 1'b1;
        end else if (e <= 10'sd0) begin
            r.res = {sign, 31'h0};
            r.unf = 1'b1;
        end else begin
            r.res = {sign, e[7:0], frac};
        end
        return r;
    endfunction

    function automatic div_out_t pack_special(input logic sign, input fp_class_e ca,
                                              input fp_class_e cb);
        div_out_t r;
        r = '0;
        if (ca == FP_NAN || cb == FP_NAN || (ca == FP_ZERO && cb == FP_ZERO) ||
            (ca == FP_INF && cb == FP_INF)) begin
            r.res = QNAN;
            r.inv = 1'b1;
        end else if (ca == FP_INF) begin
            r.res = signed_inf(sign);
        end else if (cb == FP_ZERO) begin
            r.res = signed_inf(sign);
            r.dbz = 1'b1;
        end else begin
            r.res = {sign, 31'h0};
        end
        return r;
    endfunction

    logic             ua_sign, ub_sign;
    logic [EXP_W-1:0] ua_exp, ub_exp;
    logic [MAN_W:0]   ua_man, ub_man;
    fp_class_e        ua_cls, ub_cls;

    fp32_unpack u_unpack_a (.i_op(i_a), .o_sign(ua_sign), .o_exp(ua_exp), .o_man(ua_man), .o_cls(ua_cls));
    fp32_unpack u_unpack_b (.i_op(i_b), .o_sign(ub_sign), .o_exp(ub_exp), .o_man(ub_man), .o_cls(ub_cls));

    div_state_e       state_q, state_d;
    logic             sign_q, sign_d;
    logic [EXP_W-1:0] ea_q, ea_d, eb_q, eb_d;
    logic [MAN_W:0]   mb_q, mb_d;
    fp_class_e        cls_a_q, cls_a_d, cls_b_q, cls_b_d;
    logic [24:0]      rem_q, rem_d;
    logic [QBITS-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      res_q, res_d;
    logic             res_vld_q, res_vld_d, busy_q, busy_d;
    logic             ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d, inv_q, inv_d;

    logic [24:0]        div_rem;
    logic [QBITS-1:0]   div_quo;
    logic signed [9:0]  e_base, e_pre, e_fin;
    logic [23:0]        man_pre;
    logic [24:0]        man_rnd;
    logic [22:0]        frac;
    logic               g_bit, s_bit;
    div_out_t           norm_out, spec_out;

    // Remainder stays below mb after each subtract, so the left shift never overflows 25 bits.
    always_comb begin
        div_rem = rem_q;
        div_quo = quo_q;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (div_rem >= {1'b0, mb_q}) begin
                div_rem = div_rem - {1'b0, mb_q};
                div_quo = {div_quo[QBITS-2:0], 1'b1};
            end else begin
                div_quo = {div_quo[QBITS-2:0], 1'b0};
            end
            div_rem = div_rem << 1;
        end
    end

    always_comb begin
        e_base = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q});
        if (quo_q[QBITS-1]) begin
            man_pre = quo_q[26:3];
            g_bit   = quo_q[2];
            s_bit   = (|quo_q[1:0]) | (|rem_q);
            e_pre   = e_base + BIAS_S;
        end else begin
            man_pre = quo_q[25:2];
            g_bit   = quo_q[1];
            s_bit   = quo_q[0] | (|rem_q);
            e_pre   = e_base + BIAS_S - 10'sd1;
        end
        man_rnd = round_rne(man_pre, g_bit, s_bit);
        if (man_rnd[24]) begin
            frac  = man_rnd[23:1];
            e_fin = e_pre + 10'sd1;
        end else begin
            frac  = man_rnd[22:0];
            e_fin = e_pre;
        end
        norm_out = pack_norm(sign_q, e_fin, frac);
        spec_out = pack_special(sign_q, cls_a_q, cls_b_q);
    end

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        ea_d      = ea_q;
        eb_d      = eb_q;
        mb_d      = mb_q;
        cls_a_d   = cls_a_q;
        cls_b_d   = cls_b_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        res_vld_d = 1'b0;
        busy_d    = busy_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        dbz_d     = dbz_q;
        inv_d     = inv_q;
        case (state_q)
            ST_IDLE: begin
                if (i_vld) begin
                    sign_d  = ua_sign ^ ub_sign;
                    ea_d    = ua_exp;
                    eb_d    = ub_exp;
                    mb_d    = ub_man;
                    cls_a_d = ua_cls;
                    cls_b_d = ub_cls;
                    rem_d   = {1'b0, ua_man};
                    quo_d   = '0;
                    cnt_d   = CNT_W'(ITERS - 1);
                    busy_d  = 1'b1;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    dbz_d   = 1'b0;
                    inv_d   = 1'b0;
                    state_d = (ua_cls == FP_NORMAL && ub_cls == FP_NORMAL) ? ST_DIV : ST_SPEC;
                end
            end
            ST_DIV: begin
                rem_d = div_rem;
                quo_d = div_quo;
                if (cnt_q == '0) begin
                    state_d = ST_NORM;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_NORM: begin
                res_d     = norm_out.res;
                ovf_d     = norm_out.ovf;
                unf_d     = norm_out.unf;
                dbz_d     = norm_out.dbz;
                inv_d     = norm_out.inv;
                res_vld_d = 1'b1;
                state_d   = ST_DONE;
            end
            ST_SPEC: begin
                res_d     = spec_out.res;
                ovf_d     = spec_out.ovf;
                unf_d     = spec_out.unf;
                dbz_d     = spec_out.dbz;
                inv_d     = spec_out.inv;
                res_vld_d = 1'b1;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and architected outputs reset; the divide datapath is don't-care until loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            dbz_q     <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            dbz_q     <= dbz_d;
            inv_q     <= inv_d;
        end
        sign_q  <= sign_d;
        ea_q    <= ea_d;
        eb_q    <= eb_d;
        mb_q    <= mb_d;
        cls_a_q <= cls_a_d;
        cls_b_q <= cls_b_d;
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        cnt_q   <= cnt_d;
    end

    assign o_res       = res_q;
    assign o_res_vld   = res_vld_q;
    assign o_busy      = busy_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign div_by_zero = dbz_q;
    assign invalid     = inv_q;

endmodule

// File: tb/tb_divider_32bit.sv
// Scoreboard bench for divider_32bit: two instances (1 and 3 quotient bits per cycle),
// directed corner cases plus random operands against a real-arithmetic reference model.
module tb_divider_32bit;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        int          t0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        vld     [2];
    logic [31:0] res     [2];
    logic        res_vld [2];
    logic        busy    [2];
    logic        ovf     [2];
    logic        unf     [2];
    logic        dbz     [2];
    logic        inv     [2];

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t sbq [2][$];

    localparam int ITERS [2] = '{27, 9};

    localparam logic [31:0] DA [13] = '{32'h40E00000, 32'hC0C00000, 32'h3F800000, 32'h40A00000,
        32'h00000000, 32'h7F800000, 32'h7FC00001, 32'h40000000, 32'h7F7FFFFF, 32'h00800000,
        32'h00400000, 32'hFF800000, 32'h3F800000};
    localparam logic [31:0] DB [13] = '{32'h40000000, 32'h40800000, 32'h40400000, 32'h00000000,
        32'h00000000, 32'h7F800000, 32'h3F800000, 32'hFF800000, 32'h3F000000, 32'h40000000,
        32'h3F800000, 32'h40000000, 32'hC0000000};
    localparam logic [31:0] DR [13] = '{32'h40600000, 32'hBFC00000, 32'h3EAAAAAB, 32'h7F800000,
        32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h80000000, 32'h7F800000, 32'h00000000,
        32'h00000000, 32'hFF800000, 32'hBF000000};
    // flags as {overflow, underflow, div_by_zero, invalid}
    localparam logic [3:0] DF [13] = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h1, 4'h1, 4'h1, 4'h0, 4'h8, 4'h4,
        4'h0, 4'h0, 4'h0};
    localparam bit DS [13] = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 1, 0};

    divider_32bit #(.BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_a(a), .i_b(b), .i_vld(vld[0]), .o_res(res[0]),
        .o_res_vld(res_vld[0]), .o_busy(busy[0]), .overflow(ovf[0]), .underflow(unf[0]),
        .div_by_zero(dbz[0]), .invalid(inv[0]));

    divider_32bit #(.BITS_PER_CYCLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .i_a(a), .i_b(b), .i_vld(vld[1]), .o_res(res[1]),
        .o_res_vld(res_vld[1]), .o_busy(busy[1]), .overflow(ovf[1]), .underflow(unf[1]),
        .div_by_zero(dbz[1]), .invalid(inv[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic bit is_norm(input logic [31:0] x);
        return x[30:23] != 8'h00 && x[30:23] != 8'hFF;
    endfunction

    function automatic real fmag(input logic [31:0] x);
        return (1.0 + real'(x[22:0]) / 8388608.0) * pow2(int'(x[30:23]) - 127);
    endfunction

    // 0 zero, 1 normal, 2 inf, 3 nan
    function automatic int fclass(input logic [31:0] x);
        if (x[30:23] == 8'h00) return 0;
        if (x[30:23] != 8'hFF) return 1;
        return (x[22:0] == 23'h0) ? 2 : 3;
    endfunction

    // Quotient of exact operand values, rounded to a 24-bit significand with RNE.
    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic [3:0] f);
        logic s;
        int   cx, cy, e, mi, be;
        real  q, m, fr;
        s  = x[31] ^ y[31];
        cx = fclass(x);
        cy = fclass(y);
        f  = 4'h0;
        if (cx == 3 || cy == 3 || (cx == 0 && cy == 0) || (cx == 2 && cy == 2)) begin
            r = 32'h7FC00000; f = 4'h1;
        end else if (cx == 2) begin
            r = {s, 8'hFF, 23'h0};
        end else if (cy == 0) begin
            r = {s, 8'hFF, 23'h0}; f = 4'h2;
        end else if (cx == 0 || cy == 2) begin
            r = {s, 31'h0};
        end else begin
            q = fmag(x) / fmag(y);
            e = 0;
            while (q >= 2.0) begin q = q / 2.0; e++; end
            while (q < 1.0)  begin q = q * 2.0; e--; end
            m  = q * 8388608.0;
            mi = $rtoi(m);
            fr = m - real'(mi);
            if (fr > 0.5 || (fr == 0.5 && (mi % 2) == 1)) mi++;
            if (mi == 16777216) begin mi = 8388608; e++; end
            be = e + 127;
            if (be >= 255)     begin r = {s, 8'hFF, 23'h0}; f = 4'h8; end
            else if (be <= 0)  begin r = {s, 31'h0};        f = 4'h4; end
            else                r = {s, be[7:0], mi[22:0]};
        end
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (res_vld[d]) begin
                    if (sbq[d].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result dut%0d: got %h required no result", d, res[d]);
                    end else begin
                        e = sbq[d].pop_front();
                        check($sformatf("res_dut%0d", d), res[d], e.res);
                        check($sformatf("flags_dut%0d", d), {28'h0, ovf[d], unf[d], dbz[d], inv[d]},
                              {28'h0, e.flg});
                        check($sformatf("latency_dut%0d", d), cyc - e.t0, e.lat);
                        check($sformatf("busy_at_vld_dut%0d", d), {31'h0, busy[d]}, 32'h1);
                    end
                end
            end
        end
    endtask

    task automatic issue(input int d, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input logic [3:0] f, input int lat, input bit push);
        exp_t e;
        @(posedge clk);
        #1;
        a      = x;
        b      = y;
        vld[d] = 1'b1;
        if (push) begin
            e.res = r; e.flg = f; e.lat = lat; e.t0 = cyc;
            sbq[d].push_back(e);
        end
        @(posedge clk);
        #1;
        vld[d] = 1'b0;
    endtask

    task automatic issue_ref(input int d, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        logic [3:0]  f;
        ref_div(x, y, r, f);
        issue(d, x, y, r, f, (is_norm(x) && is_norm(y)) ? ITERS[d] + 2 : 2, 1'b1);
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        @(negedge clk);
        while ((busy[d] || sbq[d].size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL timeout_dut%0d: busy=%0d pending=%0d required idle", d, busy[d], sbq[d].size());
        end
    endtask

    task automatic run_directed(input int d);
        int n;
        for (int i = 0; i < 13; i++) begin
            wait_idle(d);
            issue(d, DA[i], DB[i], DR[i], DF[i], DS[i] ? 2 : ITERS[d] + 2, 1'b1);
            wait_idle(d);
            repeat (3) @(negedge clk);
            check($sformatf("hold_res_dut%0d_%0d", d, i), res[d], DR[i]);
            check($sformatf("hold_flags_dut%0d_%0d", d, i), {28'h0, ovf[d], unf[d], dbz[d], inv[d]},
                  {28'h0, DF[i]});
        end

        // A second strobe mid-operation must be dropped.
        wait_idle(d);
        issue(d, 32'h40E00000, 32'h40000000, 32'h40600000, 4'h0, ITERS[d] + 2, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        a = 32'h3F800000; b = 32'h40400000; vld[d] = 1'b1;
        @(posedge clk);
        #1;
        vld[d] = 1'b0;
        wait_idle(d);

        // Back-to-back: next request in the IDLE cycle right after DONE.
        issue(d, 32'hC0C00000, 32'h40800000, 32'hBFC00000, 4'h0, ITERS[d] + 2, 1'b1);
        n = 0;
        @(negedge clk);
        while (!res_vld[d] && n < 100) begin @(negedge clk); n++; end
        issue(d, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'h0, ITERS[d] + 2, 1'b1);
        wait_idle(d);

        // Reset mid-divide aborts without a result.
        issue(d, 32'h40E00000, 32'h40000000, 32'h0, 4'h0, 0, 1'b0);
        repeat ((d == 0 ? 10 : 6) - 1) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check($sformatf("abort_busy_dut%0d", d), {31'h0, busy[d]}, 32'h0);
        check($sformatf("abort_vld_dut%0d", d), {31'h0, res_vld[d]}, 32'h0);
        check($sformatf("abort_res_dut%0d", d), res[d], 32'h0);
        wait_idle(d);
        issue(d, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'h0, ITERS[d] + 2, 1'b1);
        wait_idle(d);
    endtask

    function automatic logic [31:0] rand_op(input int mode, input bit big);
        logic [31:0] v;
        v = $urandom;
        case (mode)
            0: v[30:23] = 8'($urandom_range(180, 70));
            1: v[30:23] = big ? 8'($urandom_range(254, 200)) : 8'($urandom_range(60, 1));
            default: begin
                case ($urandom_range(3))
                    0: v[30:23] = 8'h00;
                    1: v[30:23] = 8'hFF;
                    2: begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
                    default: v[30:23] = 8'($urandom_range(254, 1));
                endcase
            end
        endcase
        return v;
    endfunction

    task automatic run_random(input int d, input int count);
        int mode;
        bit big;
        for (int i = 0; i < count; i++) begin
            mode = ($urandom_range(9) < 6) ? 0 : int'($urandom_range(2, 1));
            big  = 1'($urandom_range(1));
            wait_idle(d);
            issue_ref(d, rand_op(mode, big), rand_op(mode, !big));
        end
        wait_idle(d);
        check($sformatf("drain_dut%0d", d), sbq[d].size(), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        a      = '0;
        b      = '0;
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_res_dut%0d", d), res[d], 32'h0);
            check($sformatf("reset_vld_dut%0d", d), {31'h0, res_vld[d]}, 32'h0);
            check($sformatf("reset_busy_dut%0d", d), {31'h0, busy[d]}, 32'h0);
            check($sformatf("reset_flags_dut%0d", d), {28'h0, ovf[d], unf[d], dbz[d], inv[d]}, 32'h0);
        end
        for (int d = 0; d < 2; d++) begin
            run_directed(d);
            run_random(d, 120);
        end
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
